scurve_channel_scheduler: RTL and testbench
===========================================

// Module: scurve_channel_scheduler
// PURPOSE
//  Sequences the sweep acquisition controller over a range of Microroc channels for S-curve tests.
//  Per channel: selects the Ctest channel, waits for slow-control load, runs one full DAC0 sweep,
//  acknowledges it, then advances. Owns the USB data-FIFO write port: muxes its channel header/tail
//  words with the sweep controller's data stream. Sits between the USB command decoder and the sweep controller.
// PARAMETERS
//  CONFIG_SETTLE   16'd40000  cycles waited after CtestConfigDone before starting a sweep
//  CONFIG_TIMEOUT  24'd4000000 cycles allowed for CtestConfigDone before ConfigTimeout aborts the scan
// PORTS
//  Clk                    in   1   system clock; all logic on rising edge
//  reset_n                in   1   synchronous, active-low reset
//  ScanStart              in   1   level; rising edge in IDLE starts a scan
//  ScanStop               in   1   pulse; abort request, honoured at next channel boundary
//  StartChannel           in   6   first channel (0..63)
//  EndChannel             in   6   last channel, inclusive
//  CtestChannel           out  64  one-hot Ctest enable for current channel; 0 when not scanning
//  LoadCtest              out  1   1-cycle pulse: load slow-control with CtestChannel
//  CtestConfigDone        in   1   pulse from slow-control block
//  SweepStart             out  1   level to sweep controller; high for one channel's sweep
//  SweepACQDone           in   1   level from sweep controller (its ACQDone)
//  SweepTransmitDone      out  1   1-cycle pulse; releases sweep controller to its IDLE
//  SweepACQData           in   16  sweep controller data word
//  SweepACQData_en        in   1   sweep controller data strobe
//  UsbFifoData            out  16  word to USB data FIFO
//  UsbFifoData_en         out  1   FIFO write strobe
//  UsbDataFifoFull        in   1   FIFO full
//  ScanBusy               out  1   high from scan start until DONE exit
//  ScanDone               out  1   1-cycle pulse when tail word written
//  ConfigTimeout          out  1   sticky error; cleared by next scan start
// BEHAVIOUR
//  Reset: every output 0, state IDLE, counters 0, AbortPending 0. Reset mid-scan wins in one cycle, no tail emitted.
//  States: IDLE -> CH_HEADER -> LOAD_CTEST -> WAIT_CONFIG -> SETTLE -> RUN_SWEEP -> ACK_SWEEP -> NEXT_CH
//   -> (CH_HEADER | TAIL) -> DONE -> IDLE.
//  IDLE: on ScanStart rise: Channel<=StartChannel, ConfigTimeout<=0, ScanBusy<=1; if StartChannel>EndChannel go TAIL (no sweeps).
//  CH_HEADER: write 16'hC000|{10'b0,Channel} when !UsbDataFifoFull; stall while full (word held, en low).
//  LOAD_CTEST: CtestChannel<=64'b1<<Channel; LoadCtest pulse 1 cycle; clear timeout counter.
//  WAIT_CONFIG: on CtestConfigDone -> SETTLE; counter reaches CONFIG_TIMEOUT -> ConfigTimeout<=1, go TAIL.
//  SETTLE: count CONFIG_SETTLE cycles, then SweepStart<=1 -> RUN_SWEEP.
//  RUN_SWEEP: UsbFifoData/_en follow SweepACQData/_en with 1-cycle register latency; scheduler writes nothing else.
//   On SweepACQDone=1: SweepStart<=0, -> ACK_SWEEP.
//  ACK_SWEEP: SweepTransmitDone pulse 1 cycle; wait SweepACQDone=0 -> NEXT_CH.
//  NEXT_CH: if AbortPending or Channel==EndChannel -> TAIL; else Channel<=Channel+1 -> CH_HEADER.
//   Compare before increment: EndChannel=63 never wraps to 0.
//  ScanStop: sets AbortPending in any non-IDLE state; never cuts a running sweep. Cleared in IDLE.
//  TAIL: CtestChannel<=0; write 16'hFF43 when !UsbDataFifoFull (stall while full). DONE: ScanDone pulse, ScanBusy<=0.
//  Outside RUN_SWEEP, SweepACQData_en is ignored (not forwarded). ScanStart held high after DONE does not restart; needs new rise.
// TESTING
//  Start=5,End=7, ideal sweep model -> headers C005,C006,C007 each before its sweep data, then FF43; ScanDone once.
//  Start=9,End=3 -> only FF43 written, no LoadCtest, no SweepStart, ScanDone after tail.
//  Start=End=63 -> one sweep, CtestChannel=1<<63, tail follows; Channel never wraps to 0.
//  ScanStop mid-sweep of ch 10 (range 10..20) -> ch 10 sweep completes and acked, no C00B header, FF43 written.
//  CtestConfigDone withheld -> ConfigTimeout=1 after CONFIG_TIMEOUT cycles, tail written, ScanBusy low.
//  UsbDataFifoFull held 50 cycles during CH_HEADER/TAIL -> no write while full, word written exactly once after.

Source files
------------

// File: rtl/scurve_channel_scheduler.sv
// Channel-level sequencer for Microroc S-curve scans: walks StartChannel..EndChannel,
// drives one DAC0 sweep per channel and owns the USB data-FIFO write port.
module scurve_channel_scheduler #(
    parameter logic [15:0] CONFIG_SETTLE  = 16'd40000,
    parameter logic [23:0] CONFIG_TIMEOUT = 24'd4000000
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        ScanStart,
    input  logic        ScanStop,
    input  logic [5:0]  StartChannel,
    input  logic [5:0]  EndChannel,
    output logic [63:0] CtestChannel,
    output logic        LoadCtest,
    input  logic        CtestConfigDone,
    output logic        SweepStart,
    input  logic        SweepACQDone,
    output logic        SweepTransmitDone,
    input  logic [15:0] SweepACQData,
    input  logic        SweepACQData_en,
    output logic [15:0] UsbFifoData,
    output logic        UsbFifoData_en,
    input  logic        UsbDataFifoFull,
    output logic        ScanBusy,
    output logic        ScanDone,
    output logic        ConfigTimeout
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_CH_HEADER   = 4'd1,
        S_LOAD_CTEST  = 4'd2,
        S_WAIT_CONFIG = 4'd3,
        S_SETTLE      = 4'd4,
        S_RUN_SWEEP   = 4'd5,
        S_ACK_SWEEP   = 4'd6,
        S_NEXT_CH     = 4'd7,
        S_TAIL        = 4'd8,
        S_DONE        = 4'd9
    } state_t;

    localparam logic [15:0] HEADER_BASE = 16'hC000;
    localparam logic [15:0] TAIL_WORD   = 16'hFF43;
    localparam logic [23:0] SETTLE_LIM  = {8'd0, CONFIG_SETTLE};

    state_t      state_q, state_d;
    logic [5:0]  channel_q, channel_d;
    logic [23:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        start_prev_q, start_prev_d;
    logic [63:0] ctest_q, ctest_d;
    logic        load_ctest_q, load_ctest_d;
    logic        sweep_start_q, sweep_start_d;
    logic        transmit_done_q, transmit_done_d;
    logic [15:0] fifo_data_q, fifo_data_d;
    logic        fifo_en_q, fifo_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    // Next-state and next-output computation for the whole scheduler.
    always_comb begin
        state_d         = state_q;
        channel_d       = channel_q;
        cnt_d           = cnt_q;
        abort_d         = abort_q | (ScanStop & (state_q != S_IDLE));
        start_prev_d    = ScanStart;
        ctest_d         = ctest_q;
        load_ctest_d    = 1'b0;
        sweep_start_d   = sweep_start_q;
        transmit_done_d = 1'b0;
        fifo_data_d     = fifo_data_q;
        fifo_en_d       = 1'b0;
        busy_d          = busy_q;
        done_d          = 1'b0;
        timeout_d       = timeout_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (ScanStart && !start_prev_q) begin
                    channel_d = StartChannel;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    if (StartChannel > EndChannel) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_CH_HEADER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            // The header word is held on the bus while the FIFO is full.
            S_CH_HEADER: begin
                fifo_data_d = HEADER_BASE | {10'd0, channel_q};
                if (!UsbDataFifoFull) begin
                    fifo_en_d = 1'b1;
                    state_d   = S_LOAD_CTEST;
                end else begin
                    fifo_en_d = 1'b0;
                end
            end
            S_LOAD_CTEST: begin
                ctest_d      = 64'd1 << channel_q;
                load_ctest_d = 1'b1;
                cnt_d        = 24'd0;
                state_d      = S_WAIT_CONFIG;
            end
            S_WAIT_CONFIG: begin
                if (CtestConfigDone) begin
                    cnt_d   = 24'd0;
                    state_d = S_SETTLE;
                end else if ((cnt_q + 24'd1) >= CONFIG_TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = S_TAIL;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_SETTLE: begin
                if ((cnt_q + 24'd1) >= SETTLE_LIM) begin
                    sweep_start_d = 1'b1;
                    state_d       = S_RUN_SWEEP;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_RUN_SWEEP: begin
                fifo_data_d = SweepACQData;
                fifo_en_d   = SweepACQData_en;
                if (SweepACQDone) begin
                    sweep_start_d   = 1'b0;
                    transmit_done_d = 1'b1;
                    state_d         = S_ACK_SWEEP;
                end else begin
                    state_d = S_RUN_SWEEP;
                end
            end
            S_ACK_SWEEP: begin
                if (!SweepACQDone) begin
                    state_d = S_NEXT_CH;
                end else begin
                    state_d = S_ACK_SWEEP;
                end
            end
            // Compare before incrementing so EndChannel=63 cannot wrap to 0.
            S_NEXT_CH: begin
                if (abort_q || ScanStop || (channel_q == EndChannel)) begin
                    state_d = S_TAIL;
                end else begin
                    channel_d = channel_q + 6'd1;
                    state_d   = S_CH_HEADER;
                end
            end
            S_TAIL: begin
                ctest_d     = 64'd0;
                fifo_data_d = TAIL_WORD;
                if (!UsbDataFifoFull) begin
                    fifo_en_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    fifo_en_d = 1'b0;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d       = S_IDLE;
                sweep_start_d = 1'b0;
                busy_d        = 1'b0;
                ctest_d       = 64'd0;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            channel_q       <= 6'd0;
            cnt_q           <= 24'd0;
            abort_q         <= 1'b0;
            start_prev_q    <= 1'b0;
            ctest_q         <= 64'd0;
            load_ctest_q    <= 1'b0;
            sweep_start_q   <= 1'b0;
            transmit_done_q <= 1'b0;
            fifo_data_q     <= 16'd0;
            fifo_en_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            channel_q       <= channel_d;
            cnt_q           <= cnt_d;
            abort_q         <= abort_d;
            start_prev_q    <= start_prev_d;
            ctest_q         <= ctest_d;
            load_ctest_q    <= load_ctest_d;
            sweep_start_q   <= sweep_start_d;
            transmit_done_q <= transmit_done_d;
            fifo_data_q     <= fifo_data_d;
            fifo_en_q       <= fifo_en_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            timeout_q       <= timeout_d;
        end
    end

    assign CtestChannel      = ctest_q;
    assign LoadCtest         = load_ctest_q;
    assign SweepStart        = sweep_start_q;
    assign SweepTransmitDone = transmit_done_q;
    assign UsbFifoData       = fifo_data_q;
    assign UsbFifoData_en    = fifo_en_q;
    assign ScanBusy          = busy_q;
    assign ScanDone          = done_q;
    assign ConfigTimeout     = timeout_q;

endmodule

// File: tb/tb_scurve_channel_scheduler.sv
// Scoreboard bench: stimulus queues expected FIFO words, a negedge monitor pops and compares.
module tb_scurve_channel_scheduler;

    localparam logic [15:0] SETTLE = 16'd5;
    localparam logic [23:0] TMO    = 24'd200;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ScanStart, ScanStop;
    logic [5:0]  StartChannel, EndChannel;
    logic [63:0] CtestChannel;
    logic        LoadCtest, CtestConfigDone, SweepStart, SweepACQDone, SweepTransmitDone;
    logic [15:0] SweepACQData, UsbFifoData;
    logic        SweepACQData_en, UsbFifoData_en, UsbDataFifoFull;
    logic        ScanBusy, ScanDone, ConfigTimeout;

    scurve_channel_scheduler #(.CONFIG_SETTLE(SETTLE), .CONFIG_TIMEOUT(TMO)) dut (
        .Clk(clk), .reset_n(reset_n), .ScanStart(ScanStart), .ScanStop(ScanStop),
        .StartChannel(StartChannel), .EndChannel(EndChannel), .CtestChannel(CtestChannel),
        .LoadCtest(LoadCtest), .CtestConfigDone(CtestConfigDone), .SweepStart(SweepStart),
        .SweepACQDone(SweepACQDone), .SweepTransmitDone(SweepTransmitDone),
        .SweepACQData(SweepACQData), .SweepACQData_en(SweepACQData_en),
        .UsbFifoData(UsbFifoData), .UsbFifoData_en(UsbFifoData_en),
        .UsbDataFifoFull(UsbDataFifoFull), .ScanBusy(ScanBusy), .ScanDone(ScanDone),
        .ConfigTimeout(ConfigTimeout)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    int wr_cnt = 0, load_cnt = 0, ss_cnt = 0, done_cnt = 0, td_cnt = 0;
    logic ss_prev = 1'b0;
    logic [63:0] ctest_at_load = 64'd0;
    int sweep_seq = 0, exp_seq = 0;
    logic withhold_cfg = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on every FIFO write plus event counters.
    always @(negedge clk) begin
        if (reset_n) begin
            if (UsbFifoData_en) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_word: got %h, expected no write", UsbFifoData);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (UsbFifoData !== mon_exp) begin
                        errors++;
                        $display("FAIL fifo_word: got %h, expected %h", UsbFifoData, mon_exp);
                    end
                end
            end
            if (LoadCtest) begin
                load_cnt++;
                ctest_at_load = CtestChannel;
            end
            if (SweepStart && !ss_prev) ss_cnt++;
            ss_prev = SweepStart;
            if (ScanDone) done_cnt++;
            if (SweepTransmitDone) td_cnt++;
        end
    end

    // Slow-control model: CtestConfigDone three cycles after LoadCtest unless withheld.
    initial begin
        CtestConfigDone = 1'b0;
        forever begin
            @(negedge clk);
            if (LoadCtest && !withhold_cfg) begin
                repeat (3) @(posedge clk);
                #1 CtestConfigDone = 1'b1;
                @(posedge clk);
                #1 CtestConfigDone = 1'b0;
            end
        end
    end

    // Ideal sweep controller: three data words, ACQDone until TransmitDone.
    initial begin
        SweepACQDone = 1'b0; SweepACQData = 16'd0; SweepACQData_en = 1'b0;
        forever begin
            @(negedge clk);
            if (SweepStart && reset_n) begin
                for (int w = 0; w < 3; w++) begin
                    @(posedge clk);
                    #1 SweepACQData = 16'hA000 + sweep_seq[15:0]; SweepACQData_en = 1'b1;
                    sweep_seq++;
                    @(posedge clk);
                    #1 SweepACQData_en = 1'b0;
                end
                @(posedge clk);
                #1 SweepACQDone = 1'b1;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (SweepTransmitDone) break;
                end
                @(posedge clk);
                #1 SweepACQDone = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        load_cnt = 0; ss_cnt = 0; done_cnt = 0; td_cnt = 0;
    endtask

    task automatic push_channel(input logic [5:0] ch, input bit sweep);
        exp_q.push_back(16'hC000 | {10'd0, ch});
        if (sweep) begin
            for (int w = 0; w < 3; w++) begin
                exp_q.push_back(16'hA000 + exp_seq[15:0]);
                exp_seq++;
            end
        end
    endtask

    task automatic start_scan(input logic [5:0] s, input logic [5:0] e);
        StartChannel = s; EndChannel = e;
        ScanStart = 1'b1;
    endtask

    // Waits for ScanDone, then holds ScanStart high to show it does not restart.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ScanDone) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got no ScanDone, expected ScanDone", name);
        end
        cyc(10);
        check({name, "_busy_after"}, {63'd0, ScanBusy}, 64'd0);
        check({name, "_done_once"}, done_cnt, 1);
        ScanStart = 1'b0;
        cyc(2);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int wr0;
        bit seen;
        reset_n = 1'b0; ScanStart = 1'b0; ScanStop = 1'b0;
        StartChannel = 6'd0; EndChannel = 6'd0; UsbDataFifoFull = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ctest", CtestChannel, 64'd0);
        check("rst_outs", {UsbFifoData, UsbFifoData_en, LoadCtest, SweepStart,
                           SweepTransmitDone, ScanBusy, ScanDone, ConfigTimeout}, 64'd0);
        cyc(2);

        // Range 5..7
        clear_counts();
        push_channel(6'd5, 1'b1); push_channel(6'd6, 1'b1); push_channel(6'd7, 1'b1);
        exp_q.push_back(16'hFF43);
        start_scan(6'd5, 6'd7);
        cyc(2);
        check("t1_busy", {63'd0, ScanBusy}, 64'd1);
        wait_done("t1");
        check("t1_sweeps", ss_cnt, 3);
        check("t1_loads", load_cnt, 3);

        // Empty range 9..3
        clear_counts();
        exp_q.push_back(16'hFF43);
        start_scan(6'd9, 6'd3);
        wait_done("t2");
        check("t2_loads", load_cnt, 0);
        check("t2_sweeps", ss_cnt, 0);

        // Top channel 63
        clear_counts();
        push_channel(6'd63, 1'b1);
        exp_q.push_back(16'hFF43);
        start_scan(6'd63, 6'd63);
        wait_done("t3");
        check("t3_ctest", ctest_at_load, 64'h8000_0000_0000_0000);
        check("t3_sweeps", ss_cnt, 1);
        check("t3_ctest_idle", CtestChannel, 64'd0);

        // ScanStop during channel 10 sweep
        clear_counts();
        push_channel(6'd10, 1'b1);
        exp_q.push_back(16'hFF43);
        start_scan(6'd10, 6'd20);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (SweepStart) begin seen = 1'b1; break; end
        end
        check("t4_sweep_seen", {63'd0, seen}, 64'd1);
        cyc(1);
        ScanStop = 1'b1;
        cyc(1);
        ScanStop = 1'b0;
        wait_done("t4");
        check("t4_acks", td_cnt, 1);
        check("t4_sweeps", ss_cnt, 1);

        // Config timeout
        clear_counts();
        withhold_cfg = 1'b1;
        push_channel(6'd4, 1'b0);
        exp_q.push_back(16'hFF43);
        start_scan(6'd4, 6'd4);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (LoadCtest) begin seen = 1'b1; break; end
        end
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (ConfigTimeout) break;
        end
        check("t5_timeout_cycles", n, 200);
        wait_done("t5");
        check("t5_timeout_sticky", {63'd0, ConfigTimeout}, 64'd1);
        check("t5_sweeps", ss_cnt, 0);
        withhold_cfg = 1'b0;

        // FIFO full held across header and tail
        clear_counts();
        push_channel(6'd2, 1'b1);
        exp_q.push_back(16'hFF43);
        UsbDataFifoFull = 1'b1;
        wr0 = wr_cnt;
        start_scan(6'd2, 6'd2);
        cyc(2);
        check("t6_timeout_cleared", {63'd0, ConfigTimeout}, 64'd0);
        cyc(48);
        check("t6_hdr_no_write", wr_cnt - wr0, 0);
        check("t6_hdr_no_load", load_cnt, 0);
        UsbDataFifoFull = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (SweepTransmitDone) begin seen = 1'b1; break; end
        end
        UsbDataFifoFull = 1'b1;
        wr0 = wr_cnt;
        repeat (50) @(negedge clk);
        check("t6_tail_no_write", wr_cnt - wr0, 0);
        check("t6_tail_not_done", done_cnt, 0);
        UsbDataFifoFull = 1'b0;
        wait_done("t6");

        // Reset mid-scan: no tail, everything cleared
        clear_counts();
        withhold_cfg = 1'b1;
        push_channel(6'd1, 1'b0);
        start_scan(6'd1, 6'd1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (LoadCtest) break;
        end
        cyc(5);
        ScanStart = 1'b0;
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        @(negedge clk);
        check("t7_rst_busy", {63'd0, ScanBusy}, 64'd0);
        check("t7_rst_ctest", CtestChannel, 64'd0);
        cyc(30);
        check("t7_no_done", done_cnt, 0);
        check("t7_queue_empty", exp_q.size(), 0);
        withhold_cfg = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
